// File: rtl/cpu_opponent.sv
// Automated right-hand tug-of-war player: waits for the all-lit ready pattern,
// then presses the right button after a pseudo-random reaction delay once "go" appears.
module cpu_opponent #(
  parameter int          DELAY_W      = 16,
  parameter int          MIN_DELAY    = 1000,
  parameter logic [15:0] RAND_MASK    = 16'h03FF,
  parameter int          PRESS_CYCLES = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] difficulty,
  input  logic [6:0] leds_in,
  input  logic       pbl_in,
  output logic       pb_out,
  output logic       busy,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {IDLE, ARMED, WAIT, PRESS} state_e;

  localparam logic [6:0] READY = 7'h7F;

  state_e               state_q, state_d;
  logic [DELAY_W-1:0]   cnt_q, cnt_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [7:0]           pc_q, pc_d;
  logic                 pb_q, pb_d;

  logic [DELAY_W-1:0]   min_sh, rnd_sh, dly_sum, dly;
  logic                 ready;

  assign ready = (leds_in == READY);

  // Galois form of x^16+x^14+x^13+x^11+1; maximal length, so a nonzero seed never hits zero
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Shift in 32 bits before truncating so the result matches full-precision math mod 2^DELAY_W
  always_comb begin
    min_sh  = DELAY_W'(32'(MIN_DELAY) >> difficulty);
    rnd_sh  = DELAY_W'({16'd0, lfsr_q & RAND_MASK} >> difficulty);
    dly_sum = min_sh + rnd_sh;
    dly     = (dly_sum == '0) ? DELAY_W'(1) : dly_sum;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready) state_d = ARMED;
        end
        ARMED: begin
          if (!ready) begin
            state_d = WAIT;
            cnt_d   = dly;
          end
        end
        WAIT: begin
          cnt_d = cnt_q - 1'b1;
          if (ready) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (pbl_in) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == DELAY_W'(1)) begin
            state_d = PRESS;
            cnt_d   = DELAY_W'(PRESS_CYCLES);
          end
        end
        PRESS: begin
          // the counter is reused to time the press width
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == DELAY_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (pc_q != 8'hFF) pc_d = pc_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    pb_d = (state_d == PRESS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      pc_q    <= 8'd0;
      pb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      pc_q    <= pc_d;
      pb_q    <= pb_d;
    end
  end

  assign pb_out      = pb_q;
  assign busy        = (state_q != IDLE);
  assign press_count = pc_q;

endmodule

// File: tb/tb_cpu_opponent.sv
// Directed bench for cpu_opponent: three instances cover fixed delay, forced-minimum delay
// and randomised delay against an LFSR reference.
module tb_cpu_opponent;

  logic clk;
  logic [2:0]       rst, en, pbl;
  logic [2:0][1:0]  diff;
  logic [2:0][6:0]  leds;
  wire  [2:0]       pb, bsy;
  wire  [2:0][7:0]  pc;

  int n_chk, n_err;
  logic [15:0] m_lfsr;

  cpu_opponent #(.MIN_DELAY(8), .RAND_MASK(16'h0000)) u0 (
    .clk(clk), .rst(rst[0]), .enable(en[0]), .difficulty(diff[0]), .leds_in(leds[0]),
    .pbl_in(pbl[0]), .pb_out(pb[0]), .busy(bsy[0]), .press_count(pc[0]));
  cpu_opponent #(.MIN_DELAY(2), .RAND_MASK(16'h0000)) u1 (
    .clk(clk), .rst(rst[1]), .enable(en[1]), .difficulty(diff[1]), .leds_in(leds[1]),
    .pbl_in(pbl[1]), .pb_out(pb[1]), .busy(bsy[1]), .press_count(pc[1]));
  cpu_opponent #(.MIN_DELAY(8), .RAND_MASK(16'h03FF)) u2 (
    .clk(clk), .rst(rst[2]), .enable(en[2]), .difficulty(diff[2]), .leds_in(leds[2]),
    .pbl_in(pbl[2]), .pb_out(pb[2]), .busy(bsy[2]), .press_count(pc[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR for u2: seeded on reset, one step per clock
  always @(posedge clk or negedge rst[2]) begin
    if (!rst[2]) m_lfsr <= 16'hACE1;
    else         m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until pb rises, sampled 1 time unit after each edge
  task automatic wait_rise(input int idx, input int budget, output int k);
    k = 0;
    while (pb[idx] == 1'b0 && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic wait_fall(input int idx, output int n);
    n = 0;
    while (pb[idx] == 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
  endtask

  // Counts any cycle with pb high over a window
  task automatic quiet(input int idx, input int cycles, output int highs);
    highs = 0;
    repeat (cycles) begin
      tick(1);
      if (pb[idx]) highs++;
    end
  endtask

  task automatic go(input int idx);
    leds[idx] = 7'h7F;
    tick(1);
    leds[idx] = 7'h08;
  endtask

  initial begin
    int k, n, h, exp_d;
    int durs[$];
    logic differ;
    n_chk = 0;
    n_err = 0;
    rst = '1; en = '0; pbl = '0; diff = '0; leds = '0;
    #3 rst = '0;
    tick(2);
    chk("rst_pb", 32'(pb[0]), 0);
    chk("rst_busy", 32'(bsy[0]), 0);
    chk("rst_pc", 32'(pc[0]), 0);
    rst = '1;
    en = '1;

    // fixed delay 8, difficulty 0
    leds[0] = 7'h7F;
    tick(1);
    chk("armed_busy", 32'(bsy[0]), 1);
    tick(2);
    leds[0] = 7'h08;
    wait_rise(0, 40, k);
    chk("d0_rise", k, 9);
    wait_fall(0, n);
    chk("d0_width", n, 4);
    chk("d0_pc", 32'(pc[0]), 1);
    chk("d0_idle", 32'(bsy[0]), 0);

    // difficulty 2: load 2
    diff[0] = 2'd2;
    go(0);
    wait_rise(0, 40, k);
    chk("d2_rise", k, 3);
    wait_fall(0, n);
    chk("d2_pc", 32'(pc[0]), 2);
    diff[0] = 2'd0;

    // MIN_DELAY 2, difficulty 3: load 0 forced to 1
    diff[1] = 2'd3;
    go(1);
    wait_rise(1, 40, k);
    chk("d3_rise", k, 2);
    wait_fall(1, n);
    chk("d3_pc", 32'(pc[1]), 1);

    // human presses first during WAIT
    go(0);
    tick(3);
    pbl[0] = 1'b1;
    tick(1);
    pbl[0] = 1'b0;
    chk("abort_busy", 32'(bsy[0]), 0);
    quiet(0, 12, h);
    chk("abort_nopress", h, 0);
    chk("abort_pc", 32'(pc[0]), 2);
    leds[0] = 7'h7F;
    tick(1);
    chk("abort_rearm", 32'(bsy[0]), 1);

    // new round during WAIT restarts the full delay
    leds[0] = 7'h08;
    tick(4);
    leds[0] = 7'h7F;
    tick(1);
    chk("rearm_busy", 32'(bsy[0]), 1);
    quiet(0, 10, h);
    chk("rearm_nopress", h, 0);
    leds[0] = 7'h08;
    wait_rise(0, 40, k);
    chk("rearm_rise", k, 9);
    wait_fall(0, n);
    chk("rearm_pc", 32'(pc[0]), 3);

    // enable dropped in the second press cycle
    go(0);
    wait_rise(0, 40, k);
    tick(1);
    chk("en_pb_mid", 32'(pb[0]), 1);
    en[0] = 1'b0;
    tick(1);
    chk("en_pb", 32'(pb[0]), 0);
    chk("en_busy", 32'(bsy[0]), 0);
    chk("en_pc", 32'(pc[0]), 3);
    en[0] = 1'b1;

    // async reset in WAIT
    go(0);
    tick(3);
    chk("pre_rst_busy", 32'(bsy[0]), 1);
    rst[0] = 1'b0;
    #2;
    chk("arst_busy", 32'(bsy[0]), 0);
    chk("arst_pb", 32'(pb[0]), 0);
    chk("arst_pc", 32'(pc[0]), 0);
    tick(1);
    rst[0] = 1'b1;

    // randomised delay, checked against the reference LFSR, with a reset midway
    for (int r = 0; r < 6; r++) begin
      if (r == 2) begin
        go(2);
        tick(3);
        rst[2] = 1'b0;
        #1;
        chk("u2_arst_busy", 32'(bsy[2]), 0);
        tick(1);
        rst[2] = 1'b1;
        tick(2);
      end
      go(2);
      exp_d = 8 + int'(m_lfsr & 16'h03FF);
      wait_rise(2, 1100, k);
      chk("rnd_rise", k, exp_d + 1);
      chk("rnd_range", 32'((k - 1) >= 8 && (k - 1) <= 1031), 1);
      durs.push_back(k - 1);
      wait_fall(2, n);
    end
    differ = 1'b0;
    foreach (durs[i]) if (durs[i] != durs[0]) differ = 1'b1;
    chk("rnd_varied", 32'(differ), 1);

    // saturation: u1 already holds 1
    for (int i = 0; i < 300; i++) begin
      go(1);
      tick(8);
      if (i == 252) chk("sat_254", 32'(pc[1]), 254);
    end
    chk("sat_255", 32'(pc[1]), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_opponent.md
Name: cpu_opponent

Overview:
- Automated right-hand player for the tug-of-war game: watches the 7-LED game display and drives the right pushbutton line as a responder.
- The game initiates a round with an all-LEDs-lit "ready" phase. When the LEDs leave that pattern ("go"), this block waits a pseudo-random reaction delay, then issues a fixed-width press.
- Sits beside fullTop: leds_in is fed from fullTop.leds_out; pb_out is ORed into fullTop.pbr.

Parameters:
- DELAY_W, 16, width of the reaction delay counter.
- MIN_DELAY, 1000, base reaction delay in clk cycles at difficulty 0.
- RAND_MASK, 16'h03FF, mask applied to the LFSR value for the random delay component.
- PRESS_CYCLES, 4, width of the pb_out pulse in cycles (must be >= 1).
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  1 = opponent plays; 0 = return to IDLE, pb_out held 0.
- difficulty  in  2  right-shift applied to both delay terms; 3 is fastest.
- leds_in  in  7  game LED pattern.
- pbl_in  in  1  human (left) button, already synchronised.
- pb_out  out  1  registered press output to the right button input.
- busy  out  1  high in ARMED, WAIT and PRESS.
- press_count  out  8  number of completed presses; saturates at 255.

Behaviour:
- Reset (rst=0, async): state=IDLE, pb_out=0, busy=0, press_count=0, lfsr=LFSR_SEED, counter=0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle regardless of state and never reaches zero.
- Delay load value: (MIN_DELAY>>difficulty) + ((lfsr & RAND_MASK)>>difficulty), truncated to DELAY_W.
  - lfsr and difficulty are sampled in the cycle of the ARMED->WAIT transition.
  - A computed value of 0 is forced to 1.
- States and transitions:
  - IDLE: if enable=1 and leds_in==7'h7F, go to ARMED next cycle.
  - ARMED: stay while leds_in==7'h7F. On leds_in!=7'h7F, load counter with the delay value and go to WAIT.
  - WAIT: counter decrements by 1 each cycle.
    - Priority, highest first: (1) leds_in==7'h7F, i.e. a new round began: back to ARMED, counter cleared. (2) pbl_in=1, i.e. the human responded first: back to IDLE with no press. (3) counter==1: go to PRESS; pb_out=1 starting the next cycle.
    - Load value N gives exactly N cycles in WAIT. pb_out rises on the first cycle after WAIT ends.
  - PRESS: pb_out=1 for exactly PRESS_CYCLES consecutive cycles, then go to IDLE with pb_out=0 on the following cycle.
    - press_count increments by 1 on PRESS exit, saturating at 255.
    - pbl_in and leds_in are ignored in PRESS; a press is never truncated.
- IDLE after PRESS re-arms only when leds_in shows 7'h7F again. A pattern still at 7'h7F when IDLE is entered re-arms immediately.
- enable=0 in any state: the next state is IDLE and pb_out=0 in that same next cycle. press_count is not incremented and holds its value.
- difficulty changes mid-WAIT do not affect an already-loaded counter.
- busy is decoded from the registered state, so it is glitch-free.

Test Plan:
- Params MIN_DELAY=8, RAND_MASK=0, difficulty=0. Drive leds_in=7F for 3 cycles, then 08 -> WAIT lasts 8 cycles; pb_out high exactly 4 cycles starting 9 cycles after the 7F->08 change edge; press_count=1.
- Same setup with difficulty=2 -> pb_out rises after 2+1 cycles. With MIN_DELAY=2 and difficulty=3 (load 0 forced to 1) -> pb_out rises 2 cycles after go.
- In WAIT, pulse pbl_in=1 at cycle 3 -> state IDLE, pb_out stays 0, press_count unchanged. Then leds_in=7F -> busy=1 again.
- In WAIT, return leds_in to 7F -> ARMED, no press. On the next go, the full delay restarts.
- Deassert enable mid-PRESS (cycle 2) -> pb_out=0 next cycle, IDLE, press_count unchanged. Assert rst low mid-WAIT -> all outputs 0 asynchronously, and the lfsr value after release equals ACE1.
- Run 300 rounds -> press_count saturates at 255. With RAND_MASK=03FF, every WAIT duration lies in [MIN_DELAY, MIN_DELAY+1023] and the durations are not all identical.
